// File: rtl/ps2_host_tx_if.sv
// Host-to-keyboard command port: request/status handshake plus the raw and
// open-drain views of the PS/2 clock and data lines.
interface ps2_host_tx_if;
    logic       START;
    logic [7:0] DATA;
    logic       PS2_CLK_IN;
    logic       PS2_DATA_IN;
    logic       PS2_CLK_OE;
    logic       PS2_DATA_OE;
    logic       BUSY;
    logic       DONE;
    logic       ERROR;

    modport master (
        output START, DATA, PS2_CLK_IN, PS2_DATA_IN,
        input  PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR
    );

    modport slave (
        input  START, DATA, PS2_CLK_IN, PS2_DATA_IN,
        output PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ack).
// Optional device-clock watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_TICKS = 1600,
    parameter int TIMEOUT_TICKS = 32000
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         clk_en,
    ps2_host_tx_if.slave bus
);
    localparam int MAX_TICKS = (INHIBIT_TICKS > TIMEOUT_TICKS) ? INHIBIT_TICKS : TIMEOUT_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_TICKS - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_TICKS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_XFER,
        S_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [3:0]       bit_q, bit_d;
    logic [3:0]       bit_n;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             fall;

    // clk_sync_q[1] is the synchronized clock, clk_sync_q[2] its previous value
    assign fall = clk_sync_q[2] & ~clk_sync_q[1];

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            byte_q      <= '0;
            par_q       <= 1'b0;
            tick_q      <= '0;
            bit_q       <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            byte_q      <= byte_d;
            par_q       <= par_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], bus.PS2_CLK_IN};
        data_sync_d = {data_sync_q[0], bus.PS2_DATA_IN};
        state_d     = state_q;
        byte_d      = byte_q;
        par_d       = par_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        bit_n       = bit_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.START && !busy_q) begin
                    byte_d    = bus.DATA;
                    par_d     = ~^bus.DATA;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    tick_d    = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (clk_en) begin
                    if (tick_q == INH_LAST) begin
                        data_oe_d = 1'b1;
                        state_d   = S_REQ;
                    end else begin
                        tick_d = tick_q + CNT_W'(1);
                    end
                end
            end
            S_REQ: begin
                if (clk_en) begin
                    clk_oe_d = 1'b0;
                    bit_d    = '0;
                    tick_d   = '0;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                // OE is the inverse of the wire level: drive low means a 0 bit
                if (fall) begin
                    bit_d = bit_n;
                    if (bit_n <= 4'd8) begin
                        data_oe_d = ~byte_q[bit_n[2:0] - 3'd1];
                    end else if (bit_n == 4'd9) begin
                        data_oe_d = ~par_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    done_d  = ~data_sync_q[1];
                    error_d = data_sync_q[1];
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog reuses the tick counter, which is idle once the frame is running
        if (state_q == S_XFER || state_q == S_ACK) begin
            if (fall) begin
                tick_d = '0;
            end else if (clk_en) begin
                if (tick_q == TMO_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b0;
                    error_d   = 1'b1;
                    bit_d     = '0;
                    tick_d    = '0;
                    state_d   = S_IDLE;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
        end
`endif
    end

    assign bus.PS2_CLK_OE  = clk_oe_q;
    assign bus.PS2_DATA_OE = data_oe_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.ERROR       = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain keyboard model clocks frames out of the host
// and compares the captured wire bits with a frame built from the byte.
module tb_ps2_host_tx;
    localparam int INH = 4;
    localparam int TMO = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b0;
    bit   en_all = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_err = 0;
    int n_both = 0;
    int n_busy_pulse = 0;

    ps2_host_tx_if bus ();

    assign bus.PS2_CLK_IN  = dev_clk & ~bus.PS2_CLK_OE;
    assign bus.PS2_DATA_IN = dev_data & ~bus.PS2_DATA_OE;

    ps2_host_tx #(
        .INHIBIT_TICKS(INH),
        .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk   (clk),
        .RESET (rst),
        .clk_en(clk_en),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            clk_en = en_all ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
    end

    always @(negedge clk) begin
        if (bus.DONE) n_done++;
        if (bus.ERROR) n_err++;
        if (bus.DONE && bus.ERROR) n_both++;
        if ((bus.DONE || bus.ERROR) && bus.BUSY) n_busy_pulse++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wire frame as the keyboard sees it: start, 8 data LSB first, odd parity, stop
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = ((ones % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    function automatic logic wire_data();
        return dev_data & ~bus.PS2_DATA_OE;
    endfunction

    task automatic send(input logic [7:0] b, input bit ack, input bit intrude,
                        input int abort_at, input int quit_at);
        int d0, e0, hi, i_d, i_c, cyc, w;
        bit got_req;
        logic [10:0] frame;
        d0 = n_done; e0 = n_err;
        hi = 0; i_d = -1; i_c = -1; cyc = 1; got_req = 0; frame = '0;

        @(negedge clk);
        bus.DATA  = b;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        while (cyc < 5000) begin
            if (bus.PS2_CLK_OE) hi++;
            if (bus.PS2_DATA_OE && i_d < 0) i_d = cyc;
            if (!bus.PS2_CLK_OE && hi > 0) begin
                i_c = cyc;
                got_req = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!got_req) begin
            check_val("req_seen", 32'd0, 32'd1);
            return;
        end
        if (en_all) begin
            check_val("inhibit_len", hi, INH + 1);
            check_val("data_lead", i_c - i_d, 1);
        end
        check_val("busy_mid", bus.BUSY, 1);
        frame[0] = wire_data();

        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
            repeat (4) @(negedge clk);
            dev_clk = 1'b0;
            for (int j = 0; j < 5; j++) begin
                bus.START = (intrude && k == 3 && j == 1);
                if (bus.START) bus.DATA = 8'h55;
                @(negedge clk);
            end
            bus.START = 1'b0;
            if (k <= 10) frame[k] = wire_data();
            dev_clk = 1'b1;
            if (abort_at == k) begin
                #2 rst = 1'b1;
                #1;
                check_val("rst_oe", {bus.PS2_CLK_OE, bus.PS2_DATA_OE}, 0);
                check_val("rst_busy", bus.BUSY, 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
                check_val("rst_no_pulse", (n_done - d0) + (n_err - e0), 0);
                return;
            end
            if (quit_at == k) begin
                w = 0;
                while (!bus.ERROR && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                check_val("tmo_lat", w, 8);
                repeat (2) @(negedge clk);
                check_val("tmo_err", n_err - e0, 1);
                check_val("tmo_done", n_done - d0, 0);
                check_val("tmo_oe", {bus.PS2_CLK_OE, bus.PS2_DATA_OE}, 0);
                check_val("tmo_busy", bus.BUSY, 0);
                return;
            end
        end
        dev_data = 1'b1;
        repeat (6) @(negedge clk);
        check_val("frame", frame, ref_frame(b));
        check_val("done_cnt", n_done - d0, ack ? 1 : 0);
        check_val("err_cnt", n_err - e0, ack ? 0 : 1);
        check_val("end_busy", bus.BUSY, 0);
        check_val("end_oe", {bus.PS2_CLK_OE, bus.PS2_DATA_OE}, 0);
    endtask

    initial begin
        logic [7:0] rb;
        bus.START = 1'b0;
        bus.DATA  = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_clk_oe", bus.PS2_CLK_OE, 0);
        check_val("rst_data_oe", bus.PS2_DATA_OE, 0);
        check_val("rst_busy0", bus.BUSY, 0);
        check_val("rst_pulses", {bus.DONE, bus.ERROR}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(8'hED, 1'b1, 1'b0, 0, 0);
        send(8'h07, 1'b1, 1'b0, 0, 0);
        send(8'h00, 1'b1, 1'b0, 0, 0);
        send(8'hA3, 1'b1, 1'b1, 0, 0);
        send(8'h3C, 1'b0, 1'b0, 0, 0);
        send(8'h96, 1'b1, 1'b0, 5, 0);
        send(8'h5A, 1'b1, 1'b0, 0, 0);

        en_all = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            send(rb, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 0, 0);
        end
        en_all = 1'b1;

`ifdef PS2_TX_TIMEOUT_EN
        send(8'h12, 1'b1, 1'b0, 0, 3);
        send(8'hC4, 1'b1, 1'b0, 0, 0);
`endif

        check_val("never_both", n_both, 0);
        check_val("busy_at_pulse", n_busy_pulse, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
